// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the
// dual-port RAM with self-clearing sequencer.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks a zeroing pointer across the
// array after reset or on request, then opens the ports.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear_request,
    output logic [ADDR_WIDTH-1:0] clear_address,
    output logic                  clear_write,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE  =
        {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam ram_state_e RST_STATE =
        (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    ram_state_e            state_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic                  ready_q;

    // State, clear pointer and registered ready flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST_STATE;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (count_q == LAST) begin
                        state_q <= READY;
                        count_q <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        count_q <= count_q + ONE;
                        ready_q <= 1'b0;
                    end
                end
                READY: begin
                    if (ready_q && clear_request) begin
                        state_q <= CLEAR;
                        count_q <= '0;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Zeroing strobe follows the state; pointer is the counter.
    always_comb begin
        clear_write   = (state_q == CLEAR);
        clear_address = count_q;
        ready         = ready_q;
    end

endmodule

// File: rtl/ram_dp_init.sv
// ram_dp_init: simple dual-port RAM (one write, one
// registered read) with a hardware clear sequence.
module ram_dp_init
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_MODE      = READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    input  logic                  clear_request,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] clear_address;
    logic                  clear_write;
    logic                  wr_go;
    logic                  rd_go;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_word;

    ram_clear_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_seq (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear_request (clear_request),
        .clear_address (clear_address),
        .clear_write   (clear_write),
        .ready         (ready)
    );

    // Port gating and same-address bypass selection.
    always_comb begin
        wr_go   = ready && write_enable;
        rd_go   = ready && rd_enable;
        collide = wr_go && (wr_address == rd_address);
        if ((READ_MODE == WRITE_FIRST) && collide) begin
            rd_word = data_in;
        end else begin
            rd_word = mem[rd_address];
        end
    end

    // Array write: zeroing has priority, no reset on contents.
    always_ff @(posedge clk) begin
        if (clear_write) begin
            mem[clear_address] <= '0;
        end else if (wr_go) begin
            mem[wr_address] <= data_in;
        end
    end

    // Registered read data and its one-cycle valid pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                data_out <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_init.sv
// tb_ram_dp_init: scoreboard bench, one read-first and one
// write-first instance driven by the same directed vectors.
module tb_ram_dp_init;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] wr_address;
    logic [DW-1:0] data_in;
    logic          write_enable;
    logic [AW-1:0] rd_address;
    logic          rd_enable;
    logic          clear_request;

    logic [DW-1:0] dout0, dout1;
    logic          rv0, rv1, rdy0, rdy1;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    always #5 clk = ~clk;

    ram_dp_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .READ_MODE(0), .CLEAR_ON_RESET(1)
    ) u_rf (
        .clk(clk), .reset_n(reset_n),
        .wr_address(wr_address), .data_in(data_in),
        .write_enable(write_enable),
        .rd_address(rd_address), .rd_enable(rd_enable),
        .data_out(dout0), .rd_valid(rv0),
        .clear_request(clear_request), .ready(rdy0)
    );

    ram_dp_init #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .READ_MODE(1), .CLEAR_ON_RESET(1)
    ) u_wf (
        .clk(clk), .reset_n(reset_n),
        .wr_address(wr_address), .data_in(data_in),
        .write_enable(write_enable),
        .rd_address(rd_address), .rd_enable(rd_enable),
        .data_out(dout1), .rd_valid(rv1),
        .clear_request(clear_request), .ready(rdy1)
    );

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable  = 1'b0;
        rd_enable     = 1'b0;
        clear_request = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] e0,
                        input logic [DW-1:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic rd(input logic [AW-1:0] a,
                      input logic [DW-1:0] e);
        rd_enable  = 1'b1;
        rd_address = a;
        push(e, e);
    endtask

    task automatic wr_cyc(input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        write_enable = 1'b1;
        wr_address   = a;
        data_in      = d;
        cyc();
        write_enable = 1'b0;
    endtask

    // Counts ready-low samples over DEPTH cycles, then expects ready.
    task automatic clear_wait(input string name);
        int lows0;
        int lows1;
        lows0 = 0;
        lows1 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!rdy0) lows0++;
            if (!rdy1) lows1++;
            cyc();
        end
        chk({name, " rf ready-low cycles"}, lows0, DEPTH);
        chk({name, " wf ready-low cycles"}, lows1, DEPTH);
        chk({name, " rf ready up"}, {31'd0, rdy0}, 1);
        chk({name, " wf ready up"}, {31'd0, rdy1}, 1);
    endtask

    task automatic read_all_zero();
        for (int a = 0; a < DEPTH; a++) begin
            rd(a[AW-1:0], 8'h00);
            cyc();
        end
        idle();
    endtask

    // Monitor: pop the expected word whenever a read returns.
    always @(negedge clk) begin
        if (rv0) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rf spurious rd_valid: got 1 required 0");
            end else begin
                chk("rf read data", {24'd0, dout0}, {24'd0, q0.pop_front()});
            end
        end
        if (rv1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wf spurious rd_valid: got 1 required 0");
            end else begin
                chk("wf read data", {24'd0, dout1}, {24'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        wr_address = '0;
        data_in    = '0;
        rd_address = '0;
        idle();
        repeat (2) cyc();

        chk("reset rf ready", {31'd0, rdy0}, 0);
        chk("reset wf ready", {31'd0, rdy1}, 0);
        chk("reset rf data_out", {24'd0, dout0}, 0);
        chk("reset rf rd_valid", {31'd0, rv0}, 0);

        reset_n = 1'b1;
        clear_wait("post-reset");
        read_all_zero();

        wr_cyc(4'h3, 8'hA5);
        rd(4'h3, 8'hA5);
        cyc();
        idle();
        chk("latency rf rd_valid", {31'd0, rv0}, 1);
        chk("latency wf rd_valid", {31'd0, rv1}, 1);

        wr_cyc(4'h7, 8'h11);
        write_enable = 1'b1;
        wr_address   = 4'h7;
        data_in      = 8'h22;
        rd_enable    = 1'b1;
        rd_address   = 4'h7;
        push(8'h11, 8'h22);
        cyc();
        idle();
        rd(4'h7, 8'h22);
        cyc();
        idle();

        write_enable = 1'b1;
        wr_address   = 4'h8;
        data_in      = 8'h33;
        rd(4'h3, 8'hA5);
        cyc();
        idle();
        rd(4'h8, 8'h33);
        cyc();
        idle();

        wr_cyc(4'h1, 8'hC1);
        wr_cyc(4'h2, 8'hC2);
        rd(4'h1, 8'hC1);
        cyc();
        chk("b2b rd_valid 1", {31'd0, rv0 & rv1}, 1);
        rd(4'h2, 8'hC2);
        cyc();
        chk("b2b rd_valid 2", {31'd0, rv0 & rv1}, 1);
        rd(4'h3, 8'hA5);
        cyc();
        chk("b2b rd_valid 3", {31'd0, rv0 & rv1}, 1);
        idle();
        cyc();
        chk("hold rf rd_valid", {31'd0, rv0}, 0);
        chk("hold rf data_out", {24'd0, dout0}, 32'hA5);
        chk("hold wf data_out", {24'd0, dout1}, 32'hA5);

        for (int a = 0; a < DEPTH; a++) begin
            wr_cyc(a[AW-1:0], 8'h5A);
        end
        rd(4'h0, 8'h5A);
        clear_request = 1'b1;
        cyc();
        write_enable  = 1'b1;
        wr_address    = 4'h5;
        data_in       = 8'hFF;
        rd_enable     = 1'b1;
        rd_address    = 4'h0;
        clear_request = 1'b1;
        clear_wait("clear-request");
        idle();
        read_all_zero();

        wr_cyc(4'h4, 8'h9C);
        rd(4'h4, 8'h9C);
        cyc();
        idle();
        clear_request = 1'b1;
        cyc();
        idle();
        repeat (9) cyc();
        reset_n = 1'b0;
        #1;
        chk("mid-clear reset rf data_out", {24'd0, dout0}, 0);
        chk("mid-clear reset wf rd_valid", {31'd0, rv1}, 0);
        chk("mid-clear reset rf ready", {31'd0, rdy0}, 0);
        repeat (2) cyc();
        reset_n = 1'b1;
        clear_wait("restart");
        read_all_zero();

        repeat (3) cyc();
        chk("rf queue drained", q0.size(), 0);
        chk("wf queue drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_dp_init.md
RAM_DP_INIT -- requirements
Module: ram_dp_init

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter READ_MODE, default 0; 0 = read-first, 1 = write-first on same-address collision.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero the array after reset release.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports clk and reset_n.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 wr_address  input  ADDR_WIDTH  write port address.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 write_enable  input  1  write strobe, sampled at clk.
REQ-011 rd_address  input  ADDR_WIDTH  read port address.
REQ-012 rd_enable  input  1  read request, sampled at clk.
REQ-013 data_out  output  DATA_WIDTH  registered read data.
REQ-014 rd_valid  output  1  one-cycle pulse: data_out updated this cycle.
REQ-015 clear_request  input  1  start full-array clear; accepted only when ready=1.
REQ-016 ready  output  1  high when array accepts reads/writes.

Function
REQ-017 Storage SHALL be DEPTH x DATA_WIDTH; all addresses valid, no out-of-range case.
REQ-018 FSM SHALL have states CLEAR and READY only.
REQ-019 In CLEAR: one word per cycle written with zero, clear counter 0 -> DEPTH-1; ready=0.
REQ-020 CLEAR -> READY on the cycle after the counter reaches DEPTH-1; counter returns to 0.
REQ-021 Full clear SHALL take exactly DEPTH cycles; ready rises on cycle DEPTH+1 after entry.
REQ-022 READY -> CLEAR when clear_request=1; ready deasserts on the next edge.
REQ-023 In CLEAR, write_enable, rd_enable and clear_request SHALL be ignored; rd_valid stays 0.
REQ-024 In READY, write_enable=1 SHALL store data_in at wr_address on that edge.
REQ-025 In READY, rd_enable=1 SHALL load data_out from rd_address on that edge; rd_valid=1 for exactly the following cycle (latency 1).
REQ-026 Without rd_enable, data_out SHALL hold its last value; rd_valid=0.
REQ-027 Back-to-back reads SHALL sustain one read per cycle; rd_valid stays high continuously.
REQ-028 Same-cycle read and write to one address: READ_MODE=0 returns old word, READ_MODE=1 returns data_in.
REQ-029 Read and write to different addresses in one cycle SHALL both complete, no interaction.
REQ-030 clear_request together with write_enable/rd_enable in READY: the write and read complete, then CLEAR starts.

Reset
REQ-031 reset_n=0 SHALL immediately force data_out=0, rd_valid=0, clear counter=0.
REQ-032 During reset ready=0; on release state = CLEAR if CLEAR_ON_RESET=1, else READY (ready=1 on first edge).
REQ-033 Reset asserted mid-clear SHALL abort the clear; clear restarts from address 0 after release.
REQ-034 Storage contents SHALL NOT be reset asynchronously; zeroing occurs only via CLEAR.

Structure
REQ-035 Shared package ram_pkg SHALL hold the state encoding (CLEAR, READY) and READ_MODE constants (READ_FIRST=0, WRITE_FIRST=1).
REQ-036 Clear counter and FSM SHALL be sub-module ram_clear_seq (outputs: clear address, clear write strobe, ready).
REQ-037 Array and read/write ports SHALL stay in ram_dp_init, inferable as block RAM.

Verification
REQ-038 Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> ready=0 for 16 cycles, ready=1 on cycle 17; reads of 0..15 return 0x00.
REQ-039 Write 0xA5 to 0x03, next cycle read 0x03 -> data_out=0xA5 with rd_valid=1 one cycle after rd_enable.
REQ-040 Address 0x07 holds 0x11; same cycle write 0x22 and read 0x07 -> 0x11 (READ_MODE=0), 0x22 (READ_MODE=1).
REQ-041 Fill 0x00..0x0F with 0x5A, pulse clear_request, write 0xFF during CLEAR -> write ignored, all reads 0x00 after ready.
REQ-042 reset_n low at clear counter=9, then release -> clear restarts at 0, ready after a full 16 cycles.
REQ-043 Reads of 0x01,0x02,0x03 on consecutive cycles -> rd_valid high for three cycles, data in request order.
